// File: rtl/mul_div_sequencer.sv
// rtl/mul_div_sequencer.sv - multi-cycle unsigned shift-add multiply / restoring divide unit
// One result bit per cycle; busy stalls the pipeline until the result is registered.
module mul_div_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [2:0]       flags,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic               op_q;
    logic [WIDTH-1:0]   m_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;

    logic               last_iter;
    logic               dbz_req;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_rem_next;
    logic [WIDTH-1:0]   div_q_next;

    assign last_iter = (count == CW'(WIDTH - 1));
    assign dbz_req   = op && (operand_b == '0);

    // Multiply: acc low half holds the shrinking multiplier, the carry out of the
    // upper-half add is shifted back in as the new MSB.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m_q} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc low half holds the dividend, shifted out MSB-first while quotient
    // bits shift in at the LSB. rem < divisor keeps the trial inside WIDTH+1 bits.
    assign div_shift    = {rem[WIDTH-1:0], acc[WIDTH-1]};
    assign div_trial    = div_shift - {1'b0, m_q};
    assign div_rem_next = div_trial[WIDTH] ? div_shift : div_trial;
    assign div_q_next   = {acc[WIDTH-2:0], ~div_trial[WIDTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = dbz_req ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            op_q        <= 1'b0;
            m_q         <= '0;
            acc         <= '0;
            rem         <= '0;
            result_lo   <= '0;
            result_hi   <= '0;
            flags       <= 3'b000;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dbz_req) begin
                            result_lo   <= '1;
                            result_hi   <= operand_a;
                            flags       <= 3'b000;
                            div_by_zero <= 1'b1;
                        end else begin
                            op_q  <= op;
                            m_q   <= op ? operand_b : operand_a;
                            acc   <= {{WIDTH{1'b0}}, (op ? operand_a : operand_b)};
                            rem   <= '0;
                            count <= '0;
                        end
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (op_q) begin
                        rem            <= div_rem_next;
                        acc[WIDTH-1:0] <= div_q_next;
                    end else begin
                        acc <= mul_next;
                    end
                    if (last_iter) begin
                        div_by_zero <= 1'b0;
                        if (op_q) begin
                            result_lo <= div_q_next;
                            result_hi <= div_rem_next[WIDTH-1:0];
                            flags     <= {1'b0, (div_q_next == '0), div_q_next[WIDTH-1]};
                        end else begin
                            result_lo <= mul_next[WIDTH-1:0];
                            result_hi <= mul_next[2*WIDTH-1:WIDTH];
                            flags     <= {(mul_next[2*WIDTH-1:WIDTH] != '0),
                                          (mul_next == '0),
                                          mul_next[2*WIDTH-1]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
